// File: rtl/uart_word_assembler.sv
`timescale 1ns/1ps
// Reassembles H/M/L bytes from the UART receiver into 24-bit words for the receive FIFO.
// Write request is asserted one cycle after the L byte; an idle gap mid-word discards the partial word.
module uart_word_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FULL_LEVEL     = 511
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [9:0]  wrusedw_fifo,
  output logic        wrreq_fifo_rx,
  output logic [23:0] data_fifo_rx,
  output logic [15:0] word_count,
  output logic [7:0]  drop_count,
  output logic        timeout_pulse,
  output logic        signal_to_diods_overflow
);

  typedef enum logic [1:0] {IDLE, GOT_H, GOT_M, WRITE} state_t;

  localparam logic [19:0] TIMEOUT_LIM = TIMEOUT_CYCLES[19:0];
  localparam logic [10:0] FULL_LIM    = FULL_LEVEL[10:0];

  state_t      state;
  state_t      next_state;
  logic [7:0]  byte_h;
  logic [7:0]  byte_m;
  logic [19:0] tmo_cnt;
  logic        in_word;
  logic        timeout_hit;
  logic        fifo_ok;

  assign in_word     = (state == GOT_H) || (state == GOT_M);
  // A byte arriving in the expiry cycle is still accepted as the continuation.
  assign timeout_hit = in_word && !rx_valid && (tmo_cnt == TIMEOUT_LIM);
  assign fifo_ok     = ({1'b0, wrusedw_fifo} < FULL_LIM);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (rx_valid) next_state = GOT_H;
      GOT_H: if (rx_valid) next_state = GOT_M;
             else if (timeout_hit) next_state = IDLE;
      GOT_M: if (rx_valid) next_state = WRITE;
             else if (timeout_hit) next_state = IDLE;
      WRITE: next_state = rx_valid ? GOT_H : IDLE;
    endcase
  end

  always_comb begin
    wrreq_fifo_rx = (state == WRITE) && fifo_ok;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      byte_h                   <= '0;
      byte_m                   <= '0;
      data_fifo_rx             <= '0;
      tmo_cnt                  <= '0;
      timeout_pulse            <= 1'b0;
      word_count               <= '0;
      drop_count               <= '0;
      signal_to_diods_overflow <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;

      if (rx_valid) begin
        unique case (state)
          IDLE, WRITE: byte_h       <= rx_data;
          GOT_H:       byte_m       <= rx_data;
          GOT_M:       data_fifo_rx <= {byte_h, byte_m, rx_data};
        endcase
      end else if (timeout_hit) begin
        byte_h <= '0;
        byte_m <= '0;
      end

      if (rx_valid || !in_word) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + 20'd1;

      if (state == WRITE) begin
        if (fifo_ok) begin
          word_count <= word_count + 16'd1;
        end else begin
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          signal_to_diods_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_word_assembler.md
# uart_word_assembler

Receive-side counterpart of the UART transmit path that streams 24-bit FIFO words as three bytes. Takes the byte strobe from the UART receiver and reassembles each group of H, M and L bytes (MSB first) into one 24-bit word. Writes each word into the 24-bit receive FIFO. An inter-byte timeout resynchronises framing, and FIFO-full drops are counted and flagged on a diode output.

## Interface
- TIMEOUT_CYCLES, 50000: idle cycles allowed between bytes of one word before the partial word is discarded; legal range 1..2^20-1.
- FULL_LEVEL, 511: FIFO fill level at or above which a word is dropped instead of written.
- CLK  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte, valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- wrusedw_fifo  in  10  current fill level of receive FIFO.
- wrreq_fifo_rx  out  1  one-cycle FIFO write request.
- data_fifo_rx  out  24  word to FIFO, {H,M,L}.
- word_count  out  16  words successfully written, wraps 65535->0.
- drop_count  out  8  words dropped on full FIFO, saturates at 255.
- timeout_pulse  out  1  one-cycle pulse when a partial word is discarded.
- signal_to_diods_overflow  out  1  sticky: set on first drop, cleared only by reset.

## Operation
- States: IDLE (expect H), GOT_H, GOT_M, WRITE.
- IDLE + rx_valid: latch H, go to GOT_H.
- GOT_H + rx_valid: latch M, go to GOT_M.
- GOT_M + rx_valid: latch L, go to WRITE.
- WRITE lasts exactly one cycle; the FIFO decision is made there.
  - wrusedw_fifo < FULL_LEVEL: wrreq_fifo_rx=1, word_count+1.
  - Otherwise: wrreq_fifo_rx stays 0, drop_count+1 (saturating), signal_to_diods_overflow<=1.
- rx_valid during WRITE: byte latched as the new H, next state GOT_H. Otherwise next state IDLE.
- Timeout counter (20 bit):
  - Cleared on every rx_valid and in IDLE/WRITE.
  - Increments each cycle in GOT_H/GOT_M.
  - When it equals TIMEOUT_CYCLES with rx_valid=0: go to IDLE, pulse timeout_pulse, discard latched bytes. Counters are unchanged.
- rx_valid and timeout expiry in the same cycle: rx_valid wins; byte is taken as the continuation and the counter restarts.
- data_fifo_rx holds the last assembled word between writes. It is updated when L is latched, so it is valid while wrreq_fifo_rx=1.

## Timing
- Reset values: state IDLE, wrreq_fifo_rx=0, data_fifo_rx=0, word_count=0, drop_count=0, timeout_pulse=0, signal_to_diods_overflow=0, timeout counter 0.
- Reset is asynchronous, so assertion mid-word immediately abandons the word and any pending write.
- Latency: L strobe sampled at edge n -> wrreq_fifo_rx high for cycle n+1 only.
- word_count and drop_count update at edge n+2 (end of WRITE).
- wrusedw_fifo is sampled during the WRITE cycle only.
- Back-to-back bytes every cycle are supported: one word per 3 cycles, with no byte lost.
- Timeout fires at exactly TIMEOUT_CYCLES idle cycles after the last accepted byte; timeout_pulse is 1 cycle wide.

## Test plan
- Reset then bytes 0xA5, 0x3C, 0x0F with wrusedw_fifo=0 -> one wrreq_fifo_rx pulse one cycle after the 0x0F strobe; data_fifo_rx=0xA53C0F; word_count=1.
- 6 consecutive-cycle strobes 0x01..0x06 -> two writes, 0x010203 then 0x040506, 3 cycles apart; word_count=2.
- TIMEOUT_CYCLES=10:
  - Send 0x11, idle 10 cycles -> timeout_pulse once, no write.
  - Then 0x22, 0x33, 0x44 -> data_fifo_rx=0x223344.
  - Repeat with a byte strobed exactly at idle cycle 10 -> no timeout.
- wrusedw_fifo=511 during one word -> no wrreq; drop_count=1; signal_to_diods_overflow=1. Next word with wrusedw_fifo=100 is written; overflow flag stays 1.
- 300 words at full level -> drop_count saturates at 255.
- Preload word_count to 65535 via 65535 writes (or force) -> the next write wraps it to 0.
- Assert reset between the M and L bytes -> all outputs zero immediately. The following H, M, L bytes assemble as a fresh word.
